// File: rtl/mole_pkg.sv
// Shared types and helpers for the multi-mole engine: level encodings,
// game state enum, lifetime lookup and a small popcount.
package mole_pkg;

  // Difficulty encodings; any value above HARD behaves as HARD.
  localparam logic [1:0] LVL_EASY = 2'd0;
  localparam logic [1:0] LVL_MED  = 2'd1;
  localparam logic [1:0] LVL_HARD = 2'd2;

  // Game state; exported on the debug port of the engine.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  // Lifetime in clock cycles for a difficulty level. The three lifetimes
  // are passed in so the engine's parameters stay the single source.
  function automatic logic [31:0] life_ticks(input logic [1:0]  lvl,
                                             input logic [31:0] life_easy,
                                             input logic [31:0] life_med,
                                             input logic [31:0] life_hard);
    logic [31:0] ticks;
    case (lvl)
      LVL_EASY: ticks = life_easy;
      LVL_MED:  ticks = life_med;
      default:  ticks = life_hard;
    endcase
    return ticks;
  endfunction

  // Number of set bits in a vector of up to 16 holes.
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] cnt;
    cnt = '0;
    for (int b = 0; b < 16; b++) begin
      cnt = cnt + {4'd0, v[b]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR (taps 16,14,13,11), free running from reset.
// Used as the hole-selection source; seed must be nonzero.
module lfsr16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  // Shift right every cycle, folding the output bit back into the taps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= seed;
    end else begin
      q <= {1'b0, q[15:1]} ^ (q[0] ? 16'hB400 : 16'h0000);
    end
  end

endmodule

// File: rtl/multi_mole_engine.sv
// Multi-mole game engine: lights up to MAX_ACTIVE of NUM_MOLES holes,
// each with its own lifetime timer, scores whacks and counts misses
// until MISS_LIMIT ends the game. Every output is a flop.
module multi_mole_engine
  import mole_pkg::*;
#(
  parameter int          NUM_MOLES  = 5,
  parameter int          MAX_ACTIVE = 2,
  parameter int          LIFE_EASY  = 300_000_000,
  parameter int          LIFE_MED   = 200_000_000,
  parameter int          LIFE_HARD  = 100_000_000,
  parameter int          SPAWN_GAP  = 50_000_000,
  parameter int          MISS_LIMIT = 3,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  localparam int         CW         = $clog2(NUM_MOLES + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [1:0]           level,
  input  logic [NUM_MOLES-1:0] whack_vec,
  output logic [NUM_MOLES-1:0] mole_led,
  output logic                 hit_pulse,
  output logic [CW-1:0]        hit_cnt,
  output logic                 wrong_pulse,
  output logic                 miss_pulse,
  output logic [3:0]           misses,
  output logic [CW-1:0]        active_cnt,
  output logic                 running,
  output logic                 game_over,
  output state_t               state_dbg
);

  localparam int LIFE_EM  = (LIFE_EASY > LIFE_MED) ? LIFE_EASY : LIFE_MED;
  localparam int LIFE_MAX = (LIFE_EM > LIFE_HARD) ? LIFE_EM : LIFE_HARD;
  localparam int TW       = $clog2(LIFE_MAX + 1);
  localparam int GW       = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
  localparam int HW       = $clog2(NUM_MOLES);

  localparam logic [GW-1:0] GAP_LAST  = GW'(SPAWN_GAP - 1);
  localparam logic [3:0]    MISS_LIM  = 4'(MISS_LIMIT);
  localparam logic [CW-1:0] ACT_LIMIT = CW'(MAX_ACTIVE);

  state_t                 state;
  state_t                 state_d;
  logic                   stay_run;
  logic                   enter_run;
  logic [15:0]            lfsr_q;
  logic [GW-1:0]          gap;
  logic                   spawn_en;
  logic [NUM_MOLES-1:0]   spawn_vec;
  logic [NUM_MOLES-1:0]   hit_vec;
  logic [NUM_MOLES-1:0]   exp_vec;
  logic [NUM_MOLES-1:0]   wrong_vec;
  logic [NUM_MOLES-1:0]   led_d;
  logic [TW-1:0]          life_sel;
  logic [4:0]             miss_sum;
  logic [3:0]             misses_d;
  logic                   found;
  int                     base;
  logic [HW-1:0]          pos;

  assign state_dbg = state;

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .seed (LFSR_SEED),
    .q    (lfsr_q)
  );

  // Game state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic; abort overrides everything, start is ignored in RUN.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (misses >= MISS_LIM) state_d = OVER;
      OVER:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // Game play only advances in cycles that begin and end in RUN; entering
  // or leaving RUN clears the board, timers and spawn counter.
  assign stay_run  = (state == RUN) && (state_d == RUN);
  assign enter_run = (state != RUN) && (state_d == RUN);

  // Lifetime chosen from the level presented at spawn time.
  assign life_sel = TW'(life_ticks(level, LIFE_EASY, LIFE_MED, LIFE_HARD));

  // Spawn attempts happen at the terminal gap count when a slot is free.
  assign spawn_en = stay_run && (gap == GAP_LAST) && (active_cnt < ACT_LIMIT);

  // Rotate-priority search: first hole dark at cycle start, from the LFSR index.
  always_comb begin
    spawn_vec = '0;
    found     = 1'b0;
    pos       = '0;
    base      = int'(lfsr_q % 16'(NUM_MOLES));
    for (int k = 0; k < NUM_MOLES; k++) begin
      pos = HW'((base + k) % NUM_MOLES);
      if (!found && !mole_led[pos]) begin
        spawn_vec[pos] = 1'b1;
        found          = 1'b1;
      end
    end
  end

  // Per-hole hit/expiry decode and lifetime timers. A whack on the expiry
  // cycle wins, so that hole counts as a hit and not as a miss.
  for (genvar i = 0; i < NUM_MOLES; i++) begin : g_hole
    logic [TW-1:0] timer;

    assign hit_vec[i]   = whack_vec[i] & mole_led[i];
    assign wrong_vec[i] = whack_vec[i] & ~mole_led[i];
    assign exp_vec[i]   = mole_led[i] & ~whack_vec[i] & (timer == TW'(1));

    // Load at spawn, count down while lit, clear when the mole goes away.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        timer <= '0;
      end else if (!stay_run) begin
        timer <= '0;
      end else if (spawn_en && spawn_vec[i]) begin
        timer <= life_sel;
      end else if (hit_vec[i] || exp_vec[i]) begin
        timer <= '0;
      end else if (mole_led[i]) begin
        timer <= timer - TW'(1);
      end
    end
  end

  // Board and miss count for the next cycle.
  always_comb begin
    led_d    = '0;
    miss_sum = {1'b0, misses} + popcount16(16'(exp_vec));
    misses_d = misses;
    if (enter_run) begin
      misses_d = '0;
    end else if (stay_run) begin
      led_d    = (mole_led & ~(hit_vec | exp_vec)) | (spawn_en ? spawn_vec : '0);
      misses_d = (miss_sum >= {1'b0, MISS_LIM}) ? MISS_LIM : miss_sum[3:0];
    end
  end

  // Spawn gap counter: wraps on a spawn, holds at terminal count when full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap <= '0;
    end else if (!stay_run) begin
      gap <= '0;
    end else if (gap == GAP_LAST) begin
      if (spawn_en) gap <= '0;
    end else begin
      gap <= gap + GW'(1);
    end
  end

  // Registered outputs; event pulses only for cycles played in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mole_led    <= '0;
      hit_pulse   <= 1'b0;
      hit_cnt     <= '0;
      wrong_pulse <= 1'b0;
      miss_pulse  <= 1'b0;
      misses      <= '0;
      active_cnt  <= '0;
      running     <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      mole_led    <= led_d;
      hit_pulse   <= stay_run && (|hit_vec);
      hit_cnt     <= stay_run ? CW'(popcount16(16'(hit_vec))) : '0;
      wrong_pulse <= stay_run && (|wrong_vec);
      miss_pulse  <= stay_run && (|exp_vec);
      misses      <= misses_d;
      active_cnt  <= CW'(popcount16(16'(led_d)));
      running     <= (state_d == RUN);
      game_over   <= (state_d == OVER);
    end
  end

endmodule
